// File: rtl/freq_meter.sv
// freq_meter: measures the frequency of an asynchronous square wave by
// counting its rising edges over a gate window of SYS_CLK/GATE_HZ cycles.
// The result is in Hz, with a resolution of GATE_HZ.
// Optional range alarm: define FREQ_METER_RANGE_EN to add the F_MIN/F_MAX
// comparators. Without it, Alarm is tied low.
module freq_meter #(
    parameter int SYS_CLK = 50000000,
    parameter int GATE_HZ = 1,
    parameter int CNT_W   = 32
`ifdef FREQ_METER_RANGE_EN
    ,
    parameter int F_MIN   = 0,
    parameter int F_MAX   = SYS_CLK / 2
`endif
) (
    input  logic             Clk_in,
    input  logic             Rst_n,
    input  logic             En,
    input  logic             Sig_in,
    output logic [CNT_W-1:0] Freq_out,
    output logic             Valid,
    output logic             Busy,
    output logic             Ovf,
    output logic             Alarm
);

    localparam int GATE_CYC = SYS_CLK / GATE_HZ;
    localparam int GATE_W   = (GATE_CYC > 2) ? $clog2(GATE_CYC) : 1;
    localparam int PROD_W   = CNT_W + 32;

    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // A gate window shorter than two cycles cannot hold MEASURE plus LATCH.
    if (GATE_CYC < 2) begin : g_gate_check
        $error("freq_meter: SYS_CLK/GATE_HZ must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LATCH   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                sync_1, sync_2, sync_hist;
    logic                sig_rise;
    logic [GATE_W-1:0]   gate_cnt;
    logic [CNT_W-1:0]    edge_cnt;
    logic                ovf_int;
    logic [PROD_W-1:0]   product;
    logic                prod_ovf;
    logic [CNT_W-1:0]    result;

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a true pipeline.
    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_hist <= 1'b0;
        end else begin
            sync_1    <= Sig_in;
            sync_2    <= sync_1;
            sync_hist <= sync_2;
        end
    end

    assign sig_rise = sync_2 & ~sync_hist;

    // Scale the edge count to Hz and saturate at all-ones on overflow.
    assign product  = PROD_W'(edge_cnt) * PROD_W'(GATE_HZ);
    assign prod_ovf = |product[PROD_W-1:CNT_W];
    assign result   = prod_ovf ? CNT_MAX : product[CNT_W-1:0];

    // State register.
    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Busy decode.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        case (state)
            IDLE: begin
                if (En) state_nxt = MEASURE;
            end
            MEASURE: begin
                Busy = 1'b1;
                if (!En)                  state_nxt = IDLE;
                else if (gate_cnt == '0)  state_nxt = LATCH;
            end
            LATCH: begin
                state_nxt = En ? MEASURE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gate timer, edge counter and result registers.
    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
            Freq_out <= '0;
            Valid    <= 1'b0;
            Ovf      <= 1'b0;
        end else begin
            Valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= GATE_LOAD;
                    edge_cnt <= '0;
                    ovf_int  <= 1'b0;
                end
                MEASURE: begin
                    gate_cnt <= gate_cnt - GATE_W'(1);
                    if (sig_rise) begin
                        if (edge_cnt == CNT_MAX) ovf_int  <= 1'b1;
                        else                     edge_cnt <= edge_cnt + CNT_W'(1);
                    end
                end
                LATCH: begin
                    Freq_out <= result;
                    Ovf      <= ovf_int | prod_ovf;
                    Valid    <= 1'b1;
                    gate_cnt <= GATE_LOAD;
                    // An edge seen in the latch cycle opens the next window.
                    edge_cnt <= CNT_W'(sig_rise);
                    ovf_int  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef FREQ_METER_RANGE_EN
    localparam logic [PROD_W-1:0] F_MIN_V = PROD_W'(F_MIN);
    localparam logic [PROD_W-1:0] F_MAX_V = PROD_W'(F_MAX);

    // Range alarm, refreshed together with each published result.
    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            Alarm <= 1'b0;
        end else if (state == LATCH) begin
            Alarm <= (PROD_W'(result) < F_MIN_V) || (PROD_W'(result) > F_MAX_V)
                     || ovf_int || prod_ovf;
        end
    end
`else
    assign Alarm = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: randomized self-checking bench for freq_meter.
// Two instances share the clock and Sig_in: a 32-bit meter and a 4-bit meter
// whose counter overflows. The reference model records Sig_in at every clock
// edge. For each window it counts the rising edges that fall inside the
// window, allowing for the synchronizer delay, and then applies the scaling
// and saturation rules.
module tb_freq_meter;

    localparam int SYS_CLK  = 1000;
    localparam int GATE_HZ  = 10;
    localparam int GATE_CYC = SYS_CLK / GATE_HZ;
    localparam int F_MIN_M  = 50;
    localparam int F_MAX_M  = 150;
    localparam int F_MIN_4  = 0;
    localparam int F_MAX_4  = SYS_CLK / 2;
    localparam int HMAX     = 32768;
    localparam int BUDGET   = 400;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_m  = 1'b0;
    logic        en_4  = 1'b0;
    logic        sig   = 1'b0;
    logic [31:0] freq_m;
    logic        valid_m, busy_m, ovf_m, alarm_m;
    logic [3:0]  freq_4;
    logic        valid_4, busy_4, ovf_4, alarm_4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef FREQ_METER_RANGE_EN
    freq_meter #(.SYS_CLK(SYS_CLK), .GATE_HZ(GATE_HZ), .CNT_W(32),
                 .F_MIN(F_MIN_M), .F_MAX(F_MAX_M)) dut_m (
`else
    freq_meter #(.SYS_CLK(SYS_CLK), .GATE_HZ(GATE_HZ), .CNT_W(32)) dut_m (
`endif
        .Clk_in(clk), .Rst_n(rst_n), .En(en_m), .Sig_in(sig),
        .Freq_out(freq_m), .Valid(valid_m), .Busy(busy_m), .Ovf(ovf_m), .Alarm(alarm_m));

    freq_meter #(.SYS_CLK(SYS_CLK), .GATE_HZ(GATE_HZ), .CNT_W(4)) dut_4 (
        .Clk_in(clk), .Rst_n(rst_n), .En(en_4), .Sig_in(sig),
        .Freq_out(freq_4), .Valid(valid_4), .Busy(busy_4), .Ovf(ovf_4), .Alarm(alarm_4));

    // Sig_in as seen at each rising clock edge (0 while in reset).
    int cyc = 0;
    bit hist [HMAX];
    always @(posedge clk) begin
        if (cyc < HMAX) hist[cyc] <= rst_n ? sig : 1'b0;
        cyc <= cyc + 1;
    end

    // Sig_in generator: mode 0 = static low, 1 = fixed half period, 2 = random runs.
    int mode     = 1;
    int half     = 5;
    int run_left = 5;
    initial begin
        forever begin
            @(negedge clk);
            if (mode == 0) begin
                sig = 1'b0;
            end else if (run_left <= 1) begin
                sig      = ~sig;
                run_left = (mode == 1) ? half : int'($urandom_range(2, 12));
            end else begin
                run_left--;
            end
        end
    end

    // Model state: first counting edge of the open window, per instance.
    int          win_a [2];
    bit          win_first [2];
    int          last_p;
    bit          timed_out;
    int          got_len, exp_len;
    logic [31:0] got_freq, exp_freq;
    logic        got_ovf, exp_ovf, got_alarm, exp_alarm, got_valid;

    // A rise is counted at clock edge c if Sig_in was sampled 0 then 1 at edges c-3, c-2.
    function automatic int rises(input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++)
            if (c >= 3 && hist[c-2] && !hist[c-3]) n++;
        return n;
    endfunction

    task automatic wait_valid(input int which);
        int n;
        timed_out = 1'b0;
        for (n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if ((which == 0) ? valid_m : valid_4) break;
        end
        if (n >= BUDGET) timed_out = 1'b1;
        last_p = cyc - 1;
    endtask

    // Expected result of the window ending at last_p, plus the DUT's outputs.
    task automatic expect_for(input int which);
        int     cnt;
        longint mx, c2, prod;
`ifdef FREQ_METER_RANGE_EN
        longint lo, hi;
`endif
        mx       = (which == 0) ? 64'd4294967295 : 64'd15;
        cnt      = rises(win_a[which], last_p - 1);
        c2       = (longint'(cnt) > mx) ? mx : longint'(cnt);
        prod     = c2 * GATE_HZ;
        exp_ovf  = (longint'(cnt) > mx) || (prod > mx);
        exp_freq = 32'((prod > mx) ? mx : prod);
        exp_len  = win_first[which] ? GATE_CYC : GATE_CYC + 1;
        got_len  = last_p - win_a[which];
`ifdef FREQ_METER_RANGE_EN
        lo        = (which == 0) ? F_MIN_M : F_MIN_4;
        hi        = (which == 0) ? F_MAX_M : F_MAX_4;
        exp_alarm = (longint'(exp_freq) < lo) || (longint'(exp_freq) > hi) || exp_ovf;
`else
        exp_alarm = 1'b0;
`endif
        got_freq  = (which == 0) ? freq_m : 32'(freq_4);
        got_ovf   = (which == 0) ? ovf_m : ovf_4;
        got_alarm = (which == 0) ? alarm_m : alarm_4;
        got_valid = (which == 0) ? valid_m : valid_4;
        win_a[which]     = last_p;
        win_first[which] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en_m = 1'b1; en_4 = 1'b0; mode = 1; half = 5;
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(negedge clk);
            n_vec++;
            if ({freq_m, valid_m, busy_m, ovf_m, alarm_m} !== 36'd0) begin
                n_err++;
                $display("FAIL reset_m: got %h expected 0", {freq_m, valid_m, busy_m, ovf_m, alarm_m});
            end
            n_vec++;
            if ({freq_4, valid_4, busy_4, ovf_4, alarm_4} !== 8'd0) begin
                n_err++;
                $display("FAIL reset_4: got %h expected 0", {freq_4, valid_4, busy_4, ovf_4, alarm_4});
            end
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (busy_m !== 1'b0) begin
            n_err++; $display("FAIL busy_at_release: got %b expected 0", busy_m);
        end
        @(negedge clk);
        n_vec++;
        if (busy_m !== 1'b1) begin
            n_err++; $display("FAIL busy_after_release: got %b expected 1", busy_m);
        end
        win_a[0] = cyc; win_first[0] = 1'b1;
    endtask

    task automatic test_period10;
        int seen100 = 0;
        for (int w = 0; w < 5; w++) begin
            wait_valid(0);
            n_vec++;
            if (timed_out) begin
                n_err++; $display("FAIL p10_timeout: no Valid within %0d cycles", BUDGET); return;
            end
            expect_for(0);
            n_vec++;
            if (got_len !== exp_len) begin n_err++; $display("FAIL p10_len: got %0d expected %0d", got_len, exp_len); end
            n_vec++;
            if (got_freq !== exp_freq) begin n_err++; $display("FAIL p10_freq: got %0d expected %0d", got_freq, exp_freq); end
            n_vec++;
            if (!(got_freq inside {32'd90, 32'd100, 32'd110})) begin
                n_err++; $display("FAIL p10_range: got %0d expected 90/100/110", got_freq);
            end
            n_vec++;
            if (got_ovf !== exp_ovf || got_alarm !== exp_alarm) begin
                n_err++; $display("FAIL p10_flags: got ovf=%b alarm=%b expected ovf=%b alarm=%b", got_ovf, got_alarm, exp_ovf, exp_alarm);
            end
            if (got_freq == 32'd100) seen100++;
            @(negedge clk);
            n_vec++;
            if (valid_m !== 1'b0) begin n_err++; $display("FAIL p10_valid_width: got %b expected 0", valid_m); end
        end
        n_vec++;
        if (seen100 == 0) begin n_err++; $display("FAIL p10_seen100: got %0d windows of 100 expected >0", seen100); end
    endtask

    task automatic test_static;
        mode = 0;
        for (int w = 0; w < 3; w++) begin
            wait_valid(0);
            n_vec++;
            if (timed_out) begin
                n_err++; $display("FAIL static_timeout: no Valid within %0d cycles", BUDGET); return;
            end
            expect_for(0);
            n_vec++;
            if (got_len !== exp_len || got_freq !== exp_freq || got_ovf !== exp_ovf) begin
                n_err++;
                $display("FAIL static_window: got len=%0d f=%0d ovf=%b expected len=%0d f=%0d ovf=%b", got_len, got_freq, got_ovf, exp_len, exp_freq, exp_ovf);
            end
        end
        n_vec++;
        if (got_freq !== 32'd0 || got_ovf !== 1'b0) begin
            n_err++; $display("FAIL static_zero: got f=%0d ovf=%b expected f=0 ovf=0", got_freq, got_ovf);
        end
    endtask

    task automatic test_abort;
        bit found = 1'b0;
        bit saw_valid = 1'b0;
        mode = 1; half = 5;
        for (int w = 0; w < 8 && !found; w++) begin
            wait_valid(0);
            n_vec++;
            if (timed_out) begin
                n_err++; $display("FAIL abort_timeout: no Valid within %0d cycles", BUDGET); return;
            end
            expect_for(0);
            n_vec++;
            if (got_freq !== exp_freq) begin n_err++; $display("FAIL abort_pre_freq: got %0d expected %0d", got_freq, exp_freq); end
            if (exp_freq == 32'd100 && got_freq == 32'd100) found = 1'b1;
        end
        n_vec++;
        if (!found) begin n_err++; $display("FAIL abort_no_100: got no window of 100 expected one"); return; end
        repeat (49) @(negedge clk);
        en_m = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy_m !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy_m); end
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (valid_m) saw_valid = 1'b1;
        end
        n_vec++;
        if (saw_valid) begin n_err++; $display("FAIL abort_valid: got a Valid pulse expected none"); end
        n_vec++;
        if (freq_m !== 32'd100 || ovf_m !== 1'b0) begin
            n_err++; $display("FAIL abort_hold: got f=%0d ovf=%b expected f=100 ovf=0", freq_m, ovf_m);
        end
    endtask

    task automatic test_overflow;
        mode = 1; half = 2;
        repeat (5) @(negedge clk);
        en_m = 1'b1; en_4 = 1'b1;
        @(negedge clk);
        win_a[0] = cyc; win_first[0] = 1'b1;
        win_a[1] = cyc; win_first[1] = 1'b1;
        for (int w = 0; w < 3; w++) begin
            wait_valid(0);
            n_vec++;
            if (timed_out) begin
                n_err++; $display("FAIL ovf_timeout: no Valid within %0d cycles", BUDGET); return;
            end
            if (w == 0) mode = 0;
            expect_for(0);
            n_vec++;
            if (got_len !== exp_len || got_freq !== exp_freq || got_ovf !== exp_ovf || got_alarm !== exp_alarm) begin
                n_err++;
                $display("FAIL ovf_main: got len=%0d f=%0d ovf=%b alarm=%b expected len=%0d f=%0d ovf=%b alarm=%b", got_len, got_freq, got_ovf, got_alarm, exp_len, exp_freq, exp_ovf, exp_alarm);
            end
            expect_for(1);
            n_vec++;
            if (got_valid !== 1'b1 || got_freq !== exp_freq || got_ovf !== exp_ovf || got_alarm !== exp_alarm) begin
                n_err++;
                $display("FAIL ovf_narrow: got v=%b f=%0d ovf=%b alarm=%b expected v=1 f=%0d ovf=%b alarm=%b", got_valid, got_freq, got_ovf, got_alarm, exp_freq, exp_ovf, exp_alarm);
            end
            if (w == 0) begin
                n_vec++;
                if (got_freq !== 32'd15 || got_ovf !== 1'b1) begin
                    n_err++; $display("FAIL ovf_saturate: got f=%0d ovf=%b expected f=15 ovf=1", got_freq, got_ovf);
                end
`ifdef FREQ_METER_RANGE_EN
                n_vec++;
                if (alarm_m !== 1'b1) begin n_err++; $display("FAIL alarm_high: got %b expected 1", alarm_m); end
`endif
            end
        end
        n_vec++;
        if (got_freq !== 32'd0 || got_ovf !== 1'b0) begin
            n_err++; $display("FAIL ovf_recover: got f=%0d ovf=%b expected f=0 ovf=0", got_freq, got_ovf);
        end
    endtask

    task automatic test_random;
        logic [31:0] hold;
        bit          saw_valid = 1'b0;
        int          k;
        en_4 = 1'b0; mode = 2;
        for (int w = 0; w < 12; w++) begin
            if (w == 6) begin
                // Abort at a random point inside the current window, then restart.
                hold = freq_m;
                k = int'($urandom_range(5, 95));
                repeat (k) @(negedge clk);
                en_m = 1'b0;
                @(negedge clk);
                n_vec++;
                if (busy_m !== 1'b0) begin n_err++; $display("FAIL rnd_abort_busy: got %b expected 0", busy_m); end
                for (int i = 0; i < 120; i++) begin
                    @(negedge clk);
                    if (valid_m) saw_valid = 1'b1;
                end
                n_vec++;
                if (saw_valid || freq_m !== hold) begin
                    n_err++; $display("FAIL rnd_abort_hold: got f=%0d valid_seen=%b expected f=%0d valid_seen=0", freq_m, saw_valid, hold);
                end
                en_m = 1'b1;
                @(negedge clk);
                win_a[0] = cyc; win_first[0] = 1'b1;
            end
            wait_valid(0);
            n_vec++;
            if (timed_out) begin
                n_err++; $display("FAIL rnd_timeout: no Valid within %0d cycles", BUDGET); return;
            end
            expect_for(0);
            n_vec++;
            if (got_len !== exp_len || got_freq !== exp_freq || got_ovf !== exp_ovf || got_alarm !== exp_alarm) begin
                n_err++;
                $display("FAIL rnd_window: got len=%0d f=%0d ovf=%b alarm=%b expected len=%0d f=%0d ovf=%b alarm=%b", got_len, got_freq, got_ovf, got_alarm, exp_len, exp_freq, exp_ovf, exp_alarm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_period10();
        test_static();
        test_abort();
        test_overflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
